// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light interface.
//   - 48-bit ASCII light codes, right-justified and zero-padded
//   - phase / FSM state encoding (also the value driven on the phase output)
//   - bit positions inside err_sticky
//   - next_phase(): the one legal successor of each running phase
package tl_pkg;

    // "GREEN", "YELLOW", "RED" as right-justified ASCII, upper bytes zero.
    localparam logic [47:0] LIGHT_GREEN  = 48'h00_47_52_45_45_4E;
    localparam logic [47:0] LIGHT_YELLOW = 48'h59_45_4C_4C_4F_57;
    localparam logic [47:0] LIGHT_RED    = 48'h00_00_00_52_45_44;

    // Phase encoding; doubles as the monitor FSM state encoding.
    localparam logic [1:0] PH_SYNC   = 2'b00;
    localparam logic [1:0] PH_GREEN  = 2'b01;
    localparam logic [1:0] PH_YELLOW = 2'b10;
    localparam logic [1:0] PH_RED    = 2'b11;

    // err_sticky = {code, seq, long, short}
    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;
    localparam int ERR_SEQ   = 2;
    localparam int ERR_CODE  = 3;

    // GREEN -> YELLOW -> RED -> GREEN. SYNC has no running successor.
    function automatic logic [1:0] next_phase(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            PH_GREEN:  n = PH_YELLOW;
            PH_YELLOW: n = PH_RED;
            PH_RED:    n = PH_GREEN;
            default:   n = PH_GREEN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tl_light_decode.sv
// Combinational decode of the 48-bit ASCII light code to a phase.
// Ports:
//   light  in  [48:1]  ASCII light code
//   phase  out [1:0]   PH_GREEN / PH_YELLOW / PH_RED (PH_SYNC when bad)
//   bad    out         1 when light is not one of the three known codes
module tl_light_decode
    import tl_pkg::*;
(
    input  logic [48:1] light,
    output logic [1:0]  phase,
    output logic        bad
);

    always_comb begin
        phase = PH_SYNC;
        bad   = 1'b0;
        if (light == LIGHT_GREEN) begin
            phase = PH_GREEN;
        end else if (light == LIGHT_YELLOW) begin
            phase = PH_YELLOW;
        end else if (light == LIGHT_RED) begin
            phase = PH_RED;
        end else begin
            bad = 1'b1;
        end
    end

endmodule

// File: rtl/tl_phase_monitor.sv
// Passive phase-order and dwell-time monitor for the traffic-light interface.
// One light sample is taken on every rising clk edge; all outputs are
// registered, so the effect of a sample is visible in the following cycle.
// Ports:
//   clk         in        rising-edge clock
//   rst         in        synchronous reset, active low
//   light       in [48:1] ASCII light code
//   clr         in        clears err_sticky and cycles
//   phase       out [1:0] current FSM state (00 SYNC, 01 G, 10 Y, 11 R)
//   dwell       out [CW]  samples seen in the current phase (saturating)
//   err_seq     out       pulse: illegal phase transition
//   err_code    out       pulse: unrecognised light code
//   err_short   out       pulse: phase exited before EXP-TOL samples
//   err_long    out       pulse: phase reached EXP+TOL+1 samples
//   err_sticky  out [3:0] {code, seq, long, short} accumulated
//   cycles      out [15:0] error-free GREEN->YELLOW->RED cycles (wraps)
// Handshake: none; light is sampled unconditionally every cycle.
module tl_phase_monitor
    import tl_pkg::*;
#(
    parameter int GREEN_CYC  = 30,
    parameter int YELLOW_CYC = 100,
    parameter int RED_CYC    = 100,
    parameter int TOL        = 10,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [48:1]   light,
    input  logic          clr,
    output logic [1:0]    phase,
    output logic [CW-1:0] dwell,
    output logic          err_seq,
    output logic          err_code,
    output logic          err_short,
    output logic          err_long,
    output logic [3:0]    err_sticky,
    output logic [15:0]   cycles
);

    localparam logic [CW-1:0] DWELL_MAX = {CW{1'b1}};

    logic [1:0]    code;
    logic          bad;

    // phase is the FSM state register itself.
    logic [1:0]    nxt_phase;
    logic [CW-1:0] nxt_dwell;
    logic          clean;
    logic          nxt_clean;
    logic          p_seq, p_code, p_short, p_long;
    logic          credit;
    logic [CW-1:0] lim_lo, lim_hi;

    tl_light_decode u_decode (
        .light (light),
        .phase (code),
        .bad   (bad)
    );

    // Dwell window of the phase currently being timed.
    always_comb begin
        lim_lo = '0;
        lim_hi = DWELL_MAX;
        case (phase)
            PH_GREEN: begin
                lim_lo = CW'(GREEN_CYC - TOL);
                lim_hi = CW'(GREEN_CYC + TOL);
            end
            PH_YELLOW: begin
                lim_lo = CW'(YELLOW_CYC - TOL);
                lim_hi = CW'(YELLOW_CYC + TOL);
            end
            PH_RED: begin
                lim_lo = CW'(RED_CYC - TOL);
                lim_hi = CW'(RED_CYC + TOL);
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt_phase = phase;
        nxt_dwell = dwell;
        nxt_clean = clean;
        p_seq     = 1'b0;
        p_code    = 1'b0;
        p_short   = 1'b0;
        p_long    = 1'b0;
        credit    = 1'b0;

        if (bad) begin
            p_code    = 1'b1;
            nxt_phase = PH_SYNC;
            nxt_dwell = '0;
            nxt_clean = 1'b0;
        end else if (phase == PH_SYNC) begin
            // Only GREEN opens tracking; YELLOW/RED are ignored here.
            if (code == PH_GREEN) begin
                nxt_phase = PH_GREEN;
                nxt_dwell = CW'(1);
                nxt_clean = 1'b1;
            end
        end else if (code == phase) begin
            if (dwell != DWELL_MAX) begin
                nxt_dwell = dwell + CW'(1);
            end
            // Fires only on the step from EXP+TOL to EXP+TOL+1, so once
            // per phase even when dwell later saturates.
            if (dwell == lim_hi) begin
                p_long    = 1'b1;
                nxt_clean = 1'b0;
            end
        end else if (code == next_phase(phase)) begin
            p_short   = (dwell < lim_lo);
            nxt_phase = code;
            nxt_dwell = CW'(1);
            if (phase == PH_RED) begin
                // A short RED still spoils the cycle being closed.
                credit    = clean & ~p_short;
                nxt_clean = 1'b1;
            end else if (p_short) begin
                nxt_clean = 1'b0;
            end
        end else begin
            p_seq     = 1'b1;
            nxt_phase = PH_SYNC;
            nxt_dwell = '0;
            nxt_clean = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase      <= PH_SYNC;
            dwell      <= '0;
            clean      <= 1'b0;
            err_seq    <= 1'b0;
            err_code   <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_sticky <= '0;
            cycles     <= '0;
        end else begin
            phase     <= nxt_phase;
            dwell     <= nxt_dwell;
            clean     <= nxt_clean;
            err_seq   <= p_seq;
            err_code  <= p_code;
            err_short <= p_short;
            err_long  <= p_long;
            // clr clears first; an error or credit on the same edge survives.
            err_sticky <= (clr ? 4'b0000 : err_sticky) | {p_code, p_seq, p_long, p_short};
            cycles     <= (clr ? 16'd0 : cycles) + {15'd0, credit};
        end
    end

endmodule
